// File: rtl/ntt_bank_map_gen.sv
// ntt_bank_map_gen: for each beat, generates the coefficient indices, bank selects and
// bank row addresses for a multi-lane radix-2 NTT. It walks all LOGN stages, issuing
// P butterflies (2P coefficient slots) per beat through a two-stage pipeline that
// honours backpressure.
module ntt_bank_map_gen #(
  parameter int P     = 4,
  parameter int MAP   = 3,
  parameter int LOGN  = 8,
  parameter int ADDRW = LOGN - MAP
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*P*MAP-1:0]            sel_bus,
  output logic [2*P*ADDRW-1:0]          addr_bus,
  output logic [((LOGN>1)?$clog2(LOGN):1)-1:0] stage,
  output logic                          last,
  output logic                          conflict,
  output logic                          done
);

  localparam int SLOTS = 2 * P;
  localparam int N     = 1 << LOGN;
  localparam int C     = N / SLOTS;
  localparam int CW    = (C > 1) ? $clog2(C) : 1;
  localparam int SW    = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int NF    = (LOGN + MAP - 1) / MAP;
  localparam int PW    = NF * MAP;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [SW-1:0]            s_q, s_d;
  logic [CW-1:0]            c_q, c_d;
  logic                     issue;
  logic                     en;

  logic                     v1_q;
  logic [SLOTS*LOGN-1:0]    idx1_q, idx1_d;
  logic [SW-1:0]            stage1_q;
  logic                     last1_q;
  logic [LOGN-1:0]          lo;

  logic                     v2_q;
  logic [SLOTS*MAP-1:0]     sel_q, sel_d;
  logic [SLOTS*ADDRW-1:0]   addr_q, addr_d;
  logic                     conflict_q, conflict_d;
  logic [SW-1:0]            stage2_q;
  logic                     last2_q;
  logic [SLOTS-1:0][MAP-1:0] bank_d;

  // Lower index of butterfly j in beat c of stage s: i = (b/d)*2d + b%d, where d = N>>(s+1).
  // Because d is a power of two, the division and modulo reduce to a shift and a mask.
  function automatic logic [LOGN-1:0] pairLow(input logic [SW-1:0] s, input logic [CW-1:0] c,
                                              input int j);
    logic [LOGN-1:0] b;
    logic [LOGN-1:0] mask;
    int sh;
    sh   = LOGN - 1 - int'(s);
    b    = LOGN'(int'(c) * P + j);
    mask = (LOGN'(1) << sh) - LOGN'(1);
    return ((b >> sh) << (sh + 1)) | (b & mask);
  endfunction

  // Butterfly span d for stage s.
  function automatic logic [LOGN-1:0] stride(input logic [SW-1:0] s);
    return LOGN'(1) << (LOGN - 1 - int'(s));
  endfunction

  // Bank number: the sum of MAP-bit fields modulo 2^MAP. This spreads the two halves of
  // every butterfly across different banks in most stages.
  function automatic logic [MAP-1:0] bankOf(input logic [LOGN-1:0] x);
    logic [PW-1:0]  padded;
    logic [MAP-1:0] acc;
    padded = PW'(x);
    acc    = '0;
    for (int f = 0; f < NF; f++) acc = acc + padded[f*MAP +: MAP];
    return acc;
  endfunction

  // Both pipeline stages advance together whenever the output register is empty or being drained.
  assign en = !v2_q || out_ready;

  // Sequencing FSM: chooses the next state and decides whether a new beat enters S1.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          c_d     = '0;
        end
      end
      RUN: begin
        if (en) begin
          issue = 1'b1;
          if (c_q == CW'(C - 1)) begin
            c_d = '0;
            if (s_q == SW'(LOGN - 1)) state_d = DRAIN;
            else                      s_d     = s_q + SW'(1);
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      DRAIN:   if (!v1_q && !v2_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Index pairs for the beat currently addressed by the stage/beat counters.
  always_comb begin
    idx1_d = '0;
    lo     = '0;
    for (int j = 0; j < P; j++) begin
      lo = pairLow(s_q, c_q, j);
      idx1_d[(2*j)*LOGN +: LOGN]   = lo;
      idx1_d[(2*j+1)*LOGN +: LOGN] = lo + stride(s_q);
    end
  end

  // Bank select, row address and same-beat bank collision check for the beat held in S1.
  always_comb begin
    sel_d      = '0;
    addr_d     = '0;
    bank_d     = '0;
    conflict_d = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      bank_d[k]                 = bankOf(idx1_q[k*LOGN +: LOGN]);
      sel_d[k*MAP +: MAP]       = bank_d[k];
      addr_d[k*ADDRW +: ADDRW]  = ADDRW'(idx1_q[k*LOGN +: LOGN] >> MAP);
    end
    for (int k = 0; k < SLOTS; k++) begin
      for (int m = k + 1; m < SLOTS; m++) begin
        if (bank_d[k] == bank_d[m]) conflict_d = 1'b1;
      end
    end
  end

  // State, counters and both pipeline stages; reset drops everything back to an idle, empty pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_q        <= '0;
      c_q        <= '0;
      v1_q       <= 1'b0;
      idx1_q     <= '0;
      stage1_q   <= '0;
      last1_q    <= 1'b0;
      v2_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      conflict_q <= 1'b0;
      stage2_q   <= '0;
      last2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      if (en) begin
        v1_q <= issue;
        if (issue) begin
          idx1_q   <= idx1_d;
          stage1_q <= s_q;
          last1_q  <= (c_q == CW'(C - 1));
        end
        v2_q <= v1_q;
        if (v1_q) begin
          sel_q      <= sel_d;
          addr_q     <= addr_d;
          conflict_q <= conflict_d;
          stage2_q   <= stage1_q;
          last2_q    <= last1_q;
        end
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = v2_q;
  assign sel_bus   = sel_q;
  assign addr_bus  = addr_q;
  assign stage     = stage2_q;
  assign last      = last2_q;
  assign conflict  = conflict_q;

endmodule

// File: tb/tb_ntt_bank_map_gen.sv
// Directed and scoreboarded bench for ntt_bank_map_gen with P=4, MAP=3, LOGN=8.
module tb_ntt_bank_map_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] sel_bus;
  logic [39:0] addr_bus;
  logic [2:0]  stage;
  logic        last;
  logic        conflict;
  logic        done;

  int errors = 0;
  int checks = 0;

  ntt_bank_map_gen #(.P(4), .MAP(3), .LOGN(8), .ADDRW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .sel_bus(sel_bus),
    .addr_bus(addr_bus), .stage(stage), .last(last), .conflict(conflict), .done(done)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference beat built from plain integer division/modulo and digit-sum banks.
  function automatic void modelBeat(input int beat, output logic [23:0] eSel,
                                    output logic [39:0] eAddr, output logic eConf);
    int s, c, d, b, x, sum, t;
    int bank[8];
    s = beat / 32;
    c = beat % 32;
    d = 256 >> (s + 1);
    eSel = '0;
    eAddr = '0;
    eConf = 1'b0;
    for (int k = 0; k < 8; k++) begin
      b = c * 4 + k / 2;
      x = (b / d) * 2 * d + b % d + ((k % 2 == 1) ? d : 0);
      sum = 0;
      t = x;
      for (int f = 0; f < 3; f++) begin
        sum += t % 8;
        t = t / 8;
      end
      bank[k] = sum % 8;
      eSel[k*3 +: 3] = 3'(bank[k]);
      eAddr[k*5 +: 5] = 5'(x / 8);
    end
    for (int k = 0; k < 8; k++)
      for (int m = k + 1; m < 8; m++)
        if (bank[k] == bank[m]) eConf = 1'b1;
  endfunction

  // Packs hand-written per-slot values into a bus.
  function automatic logic [23:0] packSel(input int v[8]);
    logic [23:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*3 +: 3] = 3'(v[k]);
    return r;
  endfunction

  function automatic logic [39:0] packAddr(input int v[8]);
    logic [39:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*5 +: 5] = 5'(v[k]);
    return r;
  endfunction

  // Outputs must all be zero while reset is held.
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, out_valid, last, conflict, done} !== 5'b0)
      $display("[TB] FAIL reset_flags got=%b want=00000", {busy, out_valid, last, conflict, done});
    checks++;
    if ({sel_bus, addr_bus, stage} !== 67'b0)
      $display("[TB] FAIL reset_buses got sel=%h addr=%h stage=%0d want 0", sel_bus, addr_bus, stage);
    if ({busy, out_valid, last, conflict, done} !== 5'b0 || {sel_bus, addr_bus, stage} !== 67'b0) errors++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // First-beat latency plus the hand-computed vectors for stage 0, 4 and 7, beat 0.
  task automatic test_directed_vectors();
    int beat, cyc, dones;
    logic [23:0] eSel;
    logic [39:0] eAddr;
    int s0Sel[8]  = '{0, 2, 1, 3, 2, 4, 3, 5};
    int s0Addr[8] = '{0, 16, 0, 16, 0, 16, 0, 16};
    int s4Sel[8]  = '{0, 1, 1, 2, 2, 3, 3, 4};
    int s4Addr[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int s7Sel[8]  = '{0, 1, 2, 3, 4, 5, 6, 7};
    int s7Addr[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_c1 got valid=%b busy=%b want valid=0 busy=1", out_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_c2 got valid=%b want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_c3 got valid=%b want 1", out_valid);
    end
    beat = 0;
    dones = 0;
    cyc = 0;
    while (dones == 0 && cyc < 600) begin
      cyc++;
      if (done) dones++;
      if (out_valid && (beat == 0 || beat == 128 || beat == 224)) begin
        case (beat)
          0:       begin eSel = packSel(s0Sel); eAddr = packAddr(s0Addr); end
          128:     begin eSel = packSel(s4Sel); eAddr = packAddr(s4Addr); end
          default: begin eSel = packSel(s7Sel); eAddr = packAddr(s7Addr); end
        endcase
        checks++;
        if (sel_bus !== eSel || addr_bus !== eAddr) begin
          errors++;
          $display("[TB] FAIL vec_beat%0d_bus got sel=%h addr=%h want sel=%h addr=%h",
                   beat, sel_bus, addr_bus, eSel, eAddr);
        end
        checks++;
        if (conflict !== (beat != 224) || stage !== 3'(beat / 32) || last !== 1'b0) begin
          errors++;
          $display("[TB] FAIL vec_beat%0d_meta got conf=%b stage=%0d last=%b want conf=%b stage=%0d last=0",
                   beat, conflict, stage, last, beat != 224, beat / 32);
        end
      end
      if (out_valid) beat++;
      @(negedge clk);
    end
    checks++;
    if (dones != 1 || beat != 256) begin
      errors++;
      $display("[TB] FAIL vec_run_end got beats=%0d done=%0d want beats=256 done=1", beat, dones);
    end
    repeat (2) @(negedge clk);
  endtask

  // Full transform with a beat-by-beat scoreboard, optional random ready, start pokes and a long stall.
  task automatic run_transform(input bit randReady, input bit pokeStart, input bit stall, input string tag);
    int beat, doneCnt, lastCnt, stallCnt, cyc, tail;
    logic ov, lst;
    logic [23:0] eSel, hSel;
    logic [39:0] eAddr, hAddr;
    logic eConf;
    logic [6:0] hMeta;
    beat = 0; doneCnt = 0; lastCnt = 0; stallCnt = 0; cyc = 0; tail = 0;
    hSel = '0; hAddr = '0; hMeta = '0;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 4000 && tail < 6) begin
      cyc++;
      start = 1'b0;
      if (doneCnt > 0) tail++;
      if (done) begin
        doneCnt++;
        checks++;
        if (beat != 256 || doneCnt != 1) begin
          errors++;
          $display("[TB] FAIL %s_done_pulse got beats=%0d pulses=%0d want beats=256 pulses=1", tag, beat, doneCnt);
        end
        if (pokeStart) start = 1'b1;
      end else if (pokeStart && beat == 40) begin
        start = 1'b1;
      end
      if (stall && beat == 20 && stallCnt < 10) begin
        out_ready = 1'b0;
        if (stallCnt == 0) begin
          hSel = sel_bus; hAddr = addr_bus; hMeta = {out_valid, stage, last, conflict, busy};
        end else begin
          checks++;
          if (sel_bus !== hSel || addr_bus !== hAddr || {out_valid, stage, last, conflict, busy} !== hMeta) begin
            errors++;
            $display("[TB] FAIL %s_stall_hold cycle=%0d got sel=%h addr=%h meta=%b want sel=%h addr=%h meta=%b",
                     tag, stallCnt, sel_bus, addr_bus, {out_valid, stage, last, conflict, busy}, hSel, hAddr, hMeta);
          end
        end
        stallCnt++;
      end else begin
        out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (out_valid) begin
        checks++;
        if (beat >= 256 || tail > 0) begin
          errors++;
          $display("[TB] FAIL %s_extra_beat got valid=1 at beat=%0d want valid=0", tag, beat);
        end else begin
          modelBeat(beat, eSel, eAddr, eConf);
          if (sel_bus !== eSel || addr_bus !== eAddr || conflict !== eConf ||
              stage !== 3'(beat / 32) || last !== (beat % 32 == 31)) begin
            errors++;
            $display("[TB] FAIL %s_beat%0d got sel=%h addr=%h conf=%b stage=%0d last=%b want sel=%h addr=%h conf=%b stage=%0d last=%b",
                     tag, beat, sel_bus, addr_bus, conflict, stage, last,
                     eSel, eAddr, eConf, beat / 32, beat % 32 == 31);
          end
        end
      end
      ov = out_valid;
      lst = last;
      @(posedge clk);
      if (ov && out_ready) begin
        if (lst) lastCnt++;
        beat++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (beat != 256 || doneCnt != 1 || lastCnt != 8 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_summary got beats=%0d done=%0d lasts=%0d busy=%b want 256/1/8/0",
               tag, beat, doneCnt, lastCnt, busy);
    end
    if (stall) begin
      checks++;
      if (stallCnt != 10) begin
        errors++;
        $display("[TB] FAIL %s_stall_reached got=%0d want=10", tag, stallCnt);
      end
    end
  endtask

  task automatic test_random_ready();
    run_transform(1'b1, 1'b0, 1'b0, "rand");
  endtask

  task automatic test_start_ignored();
    run_transform(1'b1, 1'b1, 1'b0, "poke");
  endtask

  task automatic test_backpressure();
    run_transform(1'b0, 1'b0, 1'b1, "stall");
  endtask

  // Asynchronous reset in the middle of a run, then a clean run from stage 0, beat 0.
  task automatic test_reset_midrun();
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL midrun_reset got valid/busy/done=%b want 000", {out_valid, busy, done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_transform(1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed_vectors();
    test_random_ready();
    test_start_ignored();
    test_backpressure();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
